// File: rtl/execute_stage.sv
// Pipeline execute stage: operand select, ALU, branch/jump resolution and the EX/MEM register.
// Define EXECUTE_FORWARD_EN to enable the ForwardAE/ForwardBE operand forwarding muxes.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        JumpE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] write_data_e;
    logic [31:0] alu_result_e;
    logic        zero_e;

`ifdef EXECUTE_FORWARD_EN
    // ALUResultM is the registered value, so forwarding from it closes no combinational loop
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = ALUResultM;
            default: write_data_e = RD2E;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^{ForwardAE, ForwardBE, ResultW};
    assign src_a        = RD1E;
    assign write_data_e = RD2E;
`endif

    assign src_b = ALUSrcE ? ImmExtE : write_data_e;

    always_comb begin
        alu_result_e = '0;
        case (ALUControlE)
            3'b000:  alu_result_e = src_a + src_b;
            3'b001:  alu_result_e = src_a - src_b;
            3'b010:  alu_result_e = src_a & src_b;
            3'b011:  alu_result_e = src_a | src_b;
            3'b101:  alu_result_e = {31'b0, ($signed(src_a) < $signed(src_b))};
            default: alu_result_e = '0;
        endcase
    end

    assign zero_e    = (alu_result_e == 32'd0);
    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & zero_e);

    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            ALUResultM <= 32'd0;
            WriteDataM <= 32'd0;
            PCPlus4M   <= 32'd0;
        end else if (!StallM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= alu_result_e;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: scoreboard of expected EX/MEM contents plus direct
// checks on the combinational branch outputs.
module tb_execute_stage;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } m_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        StallM, FlushM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    m_t act;
    m_t model_m;
    m_t exp_m;
    m_t sb[$];
    int checks = 0;
    int errors = 0;

    assign act = {RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M};

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .StallM(StallM), .FlushM(FlushM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    function automatic logic [31:0] model_alu(input logic [2:0] ctl, input logic [31:0] a,
                                              input logic [31:0] b);
        case (ctl)
            3'd0: return a + b;
            3'd1: return a + ~b + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rd);
`ifdef EXECUTE_FORWARD_EN
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return model_m.alu;
`endif
        if (sel == 2'b11) return rd;
        return rd;
    endfunction

    function automatic m_t model_next();
        m_t n;
        logic [31:0] a, wd;
        if (reset || FlushM) return '0;
        if (StallM) return model_m;
        a  = model_fwd(ForwardAE, RD1E);
        wd = model_fwd(ForwardBE, RD2E);
        n.rw  = RegWriteE;
        n.mw  = MemWriteE;
        n.rs  = ResultSrcE;
        n.rd  = RdE;
        n.alu = model_alu(ALUControlE, a, ALUSrcE ? ImmExtE : wd);
        n.wd  = wd;
        n.pc4 = PCPlus4E;
        return n;
    endfunction

    task automatic set_idle();
        reset = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        ALUSrcE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 3'b000;
        RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0; RdE = '0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0; StallM = 1'b0; FlushM = 1'b0;
    endtask

    // Predict the EX/MEM contents for the current inputs, queue them, then take one edge.
    task automatic clock_in();
        m_t e;
        e = model_next();
        model_m = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RdE = 5'd17; ALUControlE = 3'd0;
        RD1E = 32'h1234; RD2E = 32'h55; PCPlus4E = 32'h404; StallM = 1; FlushM = 0; reset = 1;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m || act !== '0) begin
            errors++; $display("FAIL reset act=%h exp=%h", act, exp_m);
        end
        // in-flight instruction is discarded by a mid-stream reset
        reset = 0; StallM = 0;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m) begin errors++; $display("FAIL reset_preload act=%h exp=%h", act, exp_m); end
        reset = 1; FlushM = 1; StallM = 1;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== '0) begin errors++; $display("FAIL reset_midstream act=%h exp=0", act); end
        reset = 0; FlushM = 0; StallM = 0; RdE = 5'd9;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m) begin errors++; $display("FAIL reset_firstload act=%h exp=%h", act, exp_m); end
        set_idle();
    endtask

    task automatic test_alu();
        logic [2:0]  ctl [8] = '{3'd1, 3'd5, 3'd5, 3'd0, 3'd2, 3'd3, 3'd7, 3'd4};
        logic [31:0] a   [8] = '{32'd5, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hF0F0, 32'hF000, 32'h77, 32'h9};
        logic [31:0] b   [8] = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'd3, 32'hFF00, 32'h000F, 32'h5, 32'h2};
        for (int i = 0; i < 8; i++) begin
            ALUControlE = ctl[i]; RD1E = a[i]; RD2E = b[i]; RdE = 5'(i + 1);
            PCPlus4E = 32'h1000 + 32'(4 * i); RegWriteE = 1;
            clock_in();
            exp_m = sb.pop_front();
            checks++;
            if (act !== exp_m) begin
                errors++; $display("FAIL alu[%0d] act=%h exp=%h", i, act, exp_m);
            end
            if (i == 0) begin
                checks++;
                if (ALUResultM !== 32'hFFFFFFFE) begin
                    errors++; $display("FAIL alu_sub act=%h exp=fffffffe", ALUResultM);
                end
            end
            if (i == 1) begin
                checks++;
                if (ALUResultM !== 32'd1) begin
                    errors++; $display("FAIL alu_slt act=%h exp=1", ALUResultM);
                end
            end
        end
        ALUSrcE = 1; ALUControlE = 3'd0; RD1E = 32'h10; RD2E = 32'hDEAD; ImmExtE = 32'hFFFFFFFC;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m || ALUResultM !== 32'hC) begin
            errors++; $display("FAIL alu_imm act=%h exp=%h", act, exp_m);
        end
        set_idle();
    endtask

    task automatic test_branch();
        BranchE = 1; ALUControlE = 3'd1; RD1E = 32'd9; RD2E = 32'd9; PCE = 32'h100;
        ImmExtE = 32'hFFFFFFF0;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF0) begin
            errors++; $display("FAIL branch_taken pcsrc=%b target=%h exp=1/000000f0", PCSrcE, PCTargetE);
        end
        RD2E = 32'd8;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin errors++; $display("FAIL branch_not_taken pcsrc=%b exp=0", PCSrcE); end
        BranchE = 0; JumpE = 1; PCE = 32'hFFFFFFF8; ImmExtE = 32'h10;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h8) begin
            errors++; $display("FAIL jump pcsrc=%b target=%h exp=1/00000008", PCSrcE, PCTargetE);
        end
        JumpE = 0; BranchE = 1; RD2E = 32'd9; reset = 1; FlushM = 1; StallM = 1;
        #1;
        checks++;
        if (PCSrcE !== 1'b1) begin errors++; $display("FAIL branch_indep pcsrc=%b exp=1", PCSrcE); end
        set_idle();
    endtask

    task automatic test_forwarding();
        ALUControlE = 3'd0; RD1E = 32'h20; RD2E = 32'h0;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m) begin errors++; $display("FAIL fwd_setup act=%h exp=%h", act, exp_m); end
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'hAB; ImmExtE = 32'd4; ALUSrcE = 1;
        RD1E = 32'h100; RD2E = 32'h33;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m) begin errors++; $display("FAIL fwd act=%h exp=%h", act, exp_m); end
        checks++;
`ifdef EXECUTE_FORWARD_EN
        if (ALUResultM !== 32'h24 || WriteDataM !== 32'hAB) begin
            errors++; $display("FAIL fwd_on alu=%h wd=%h exp=24/ab", ALUResultM, WriteDataM);
        end
`else
        if (ALUResultM !== 32'h104 || WriteDataM !== 32'h33) begin
            errors++; $display("FAIL fwd_off alu=%h wd=%h exp=104/33", ALUResultM, WriteDataM);
        end
`endif
        ForwardAE = 2'b11; ForwardBE = 2'b11; ALUSrcE = 0;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m || ALUResultM !== 32'h133) begin
            errors++; $display("FAIL fwd_11 act=%h exp=%h", act, exp_m);
        end
        set_idle();
    endtask

    task automatic test_stall_flush();
        RegWriteE = 1; RdE = 5'd3; RD1E = 32'd40; RD2E = 32'd2; ALUControlE = 3'd0; MemWriteE = 1;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m) begin errors++; $display("FAIL sf_load act=%h exp=%h", act, exp_m); end
        StallM = 1; RegWriteE = 0; RdE = 5'd21; RD1E = 32'd7; MemWriteE = 0;
        for (int i = 0; i < 2; i++) begin
            clock_in();
            exp_m = sb.pop_front();
            checks++;
            if (act !== exp_m || RegWriteM !== 1'b1 || RdM !== 5'd3) begin
                errors++; $display("FAIL stall_hold[%0d] act=%h exp=%h", i, act, exp_m);
            end
        end
        FlushM = 1;
        clock_in();
        exp_m = sb.pop_front();
        checks++;
        if (act !== exp_m || act !== '0) begin
            errors++; $display("FAIL stall_flush act=%h exp=%h", act, exp_m);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            reset = ($urandom_range(0, 15) == 0); FlushM = ($urandom_range(0, 7) == 0);
            StallM = ($urandom_range(0, 3) == 0);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
            ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom); RdE = 5'($urandom);
            RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom; PCPlus4E = $urandom;
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
            clock_in();
            exp_m = sb.pop_front();
            checks++;
            if (act !== exp_m) begin
                errors++; $display("FAIL b2b[%0d] act=%h exp=%h", i, act, exp_m);
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        model_m = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_branch();
        test_forwarding();
        test_stall_flush();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk input 1: single rising-edge clock for all state.
REQ-002 SHALL have port reset input 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have ports RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE input 1 each: execute-stage control bits.
REQ-004 SHALL have port ResultSrcE input 2: writeback result select.
REQ-005 SHALL have port ALUControlE input 3: ALU operation.
REQ-006 SHALL have ports RD1E, RD2E, PCE, ImmExtE, PCPlus4E input 32 each: operands, PC, immediate and PC+4.
REQ-007 SHALL have port RdE input 5: destination register.
REQ-008 SHALL have ports ForwardAE, ForwardBE input 2 each: operand forwarding selects.
REQ-009 SHALL have port ResultW input 32: writeback-stage result for forwarding.
REQ-010 SHALL have ports StallM, FlushM input 1 each: hold or bubble the EX/MEM register.
REQ-011 SHALL have port PCSrcE output 1: redirect fetch this cycle.
REQ-012 SHALL have port PCTargetE output 32: branch/jump target.
REQ-013 SHALL have ports RegWriteM, MemWriteM output 1 each, ResultSrcM output 2, RdM output 5: registered control.
REQ-014 SHALL have ports ALUResultM, WriteDataM, PCPlus4M output 32 each: registered data.

Function
REQ-015 SHALL select SrcAE by ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
REQ-016 SHALL select WriteDataE by ForwardBE with the same encoding applied to RD2E.
REQ-017 SHALL drive SrcBE = ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-018 SHALL compute ALUResultE: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (0/1 zero-extended), all other codes 0; arithmetic modulo 2^32, no overflow flag.
REQ-019 SHALL assert internal ZeroE when ALUResultE == 0.
REQ-020 SHALL drive PCTargetE = PCE + ImmExtE (mod 2^32), combinational.
REQ-021 SHALL drive PCSrcE = JumpE | (BranchE & ZeroE), combinational, independent of StallM, FlushM and reset.
REQ-022 SHALL update EX/MEM registers on each rising clk, priority reset > FlushM > StallM > load.
REQ-023 On load SHALL capture RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE, RdE, PCPlus4E into the matching M outputs; latency 1 cycle.
REQ-024 On FlushM SHALL clear all M outputs to 0 (bubble: no register write, no memory write).
REQ-025 On StallM without FlushM SHALL hold all M outputs unchanged.
REQ-026 SHALL use forwarded ALUResultM as the pre-edge registered value (no combinational loop).

Reset
REQ-027 reset=1 at rising clk SHALL clear RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M to 0, overriding StallM and FlushM.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight EX/MEM instruction; first valid load occurs on the first edge with reset=0.

Configuration
REQ-029 Macro EXECUTE_FORWARD_EN defined SHALL enable REQ-015/016 forwarding muxes.
REQ-030 Without EXECUTE_FORWARD_EN SHALL ignore ForwardAE, ForwardBE, ResultW and use SrcAE=RD1E, WriteDataE=RD2E; ports remain present.

Verification
REQ-031 Reset: drive reset=1 one edge with nonzero inputs -> all M outputs 0 after edge.
REQ-032 ALU: RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=001 -> ALUResultM=0xFFFFFFFE after one edge; 101 with RD1E=0xFFFFFFFF, RD2E=1 -> 1.
REQ-033 Branch: BranchE=1, ALUControlE=001, RD1E=RD2E=9, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0 same cycle; RD2E=8 -> PCSrcE=0.
REQ-034 Forwarding (macro on): ALUResultM=0x20, ForwardAE=10, ImmExtE=4, ALUSrcE=1, add -> next ALUResultM=0x24; ForwardBE=01, ResultW=0xAB -> WriteDataM=0xAB; macro off -> RD1E/RD2E used.
REQ-035 Stall/flush: load RegWriteM=1, RdM=3; StallM=1 two edges -> held; StallM=1 and FlushM=1 together -> all M outputs 0.
